// File: rtl/fp8_pkg.sv
// Shared widths, FSM state type and helpers for the mini-float sequential adder.
package fp8_pkg;

  localparam int unsigned EXP_W   = 3;
  localparam int unsigned FRAC_W  = 4;
  localparam int unsigned GUARD_W = 2;
  localparam int unsigned MANT_W  = FRAC_W + 1 + GUARD_W;
  localparam int unsigned SUM_W   = MANT_W + 1;
  localparam int unsigned SHIFT_W = $clog2(MANT_W + 1);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SHIFT,
    ADD,
    NORM,
    DONE
  } state_t;

  // Past MANT_W positions the aligned operand is already all zero.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [EXP_W-1:0] diff);
    if (int'(diff) >= int'(MANT_W)) begin
      return SHIFT_W'(MANT_W);
    end
    return SHIFT_W'(diff);
  endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Combinational normalize / saturate stage for the 8-bit mantissa sum.
// Round-to-nearest-even is compiled only when FP_ADD_ROUND_EN is defined; otherwise truncates.
module fp_norm_round
  import fp8_pkg::*;
(
  input  logic [SUM_W-1:0]  sum,
  input  logic [EXP_W-1:0]  exp_big,
  output logic [EXP_W-1:0]  res_exp,
  output logic [FRAC_W-1:0] res_fract,
  output logic              res_ovf
);

  logic [MANT_W-1:0] mant;
  logic [EXP_W:0]    exp_ext;
  logic [EXP_W:0]    exp_fin;
  logic [FRAC_W-1:0] fract;
  logic              lost_bit;
  logic              unused_bits;
`ifdef FP_ADD_ROUND_EN
  logic              round_up;
  logic [FRAC_W:0]   fract_inc;
`endif

  always_comb begin
    if (sum[SUM_W-1]) begin
      mant     = sum[SUM_W-1:1];
      exp_ext  = {1'b0, exp_big} + (EXP_W + 1)'(1);
      lost_bit = sum[0];
    end else begin
      mant     = sum[MANT_W-1:0];
      exp_ext  = {1'b0, exp_big};
      lost_bit = 1'b0;
    end
  end

`ifdef FP_ADD_ROUND_EN
  always_comb begin
    // Guard MSB is the half bit; lower guard bits and the carry-shifted bit break ties.
    round_up  = mant[GUARD_W-1] &
                ((|mant[GUARD_W-2:0]) | lost_bit | mant[GUARD_W]);
    fract_inc = {1'b0, mant[MANT_W-2 -: FRAC_W]} + (FRAC_W + 1)'(round_up);
    fract     = fract_inc[FRAC_W-1:0];
    exp_fin   = exp_ext + (EXP_W + 1)'(fract_inc[FRAC_W]);
    unused_bits = mant[MANT_W-1];
  end
`else
  always_comb begin
    fract       = mant[MANT_W-2 -: FRAC_W];
    exp_fin     = exp_ext;
    unused_bits = ^{mant[MANT_W-1], mant[GUARD_W-1:0], lost_bit};
  end
`endif

  always_comb begin
    if (exp_fin[EXP_W]) begin
      res_exp   = EXP_MAX;
      res_fract = '1;
      res_ovf   = 1'b1;
    end else begin
      res_exp   = exp_fin[EXP_W-1:0];
      res_fract = fract;
      res_ovf   = 1'b0;
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle mini-float adder: handshake in, align one bit per cycle, add, normalize, handshake out.
// Rounding mode is selected in fp_norm_round by the FP_ADD_ROUND_EN macro.
module fp_add_seq
  import fp8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  expA,
  input  logic [FRAC_W-1:0] fractA,
  input  logic [EXP_W-1:0]  expB,
  input  logic [FRAC_W-1:0] fractB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  result_exp,
  output logic [FRAC_W-1:0] result_fract,
  output logic              overflow,
  output logic              busy
);

  state_t state, state_next;

  logic [EXP_W-1:0]   exp_a, exp_b, big_exp;
  logic [FRAC_W-1:0]  fract_a, fract_b;
  logic [MANT_W-1:0]  big_mant, small_mant;
  logic [SHIFT_W-1:0] shift_cnt, align_shift;
  logic [SUM_W-1:0]   sum;

  logic               a_big;
  logic [EXP_W-1:0]   exp_diff;

  logic [EXP_W-1:0]   norm_exp;
  logic [FRAC_W-1:0]  norm_fract;
  logic               norm_ovf;

  // A wins ties so the choice of larger operand is deterministic.
  always_comb begin
    a_big       = exp_a >= exp_b;
    exp_diff    = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    align_shift = clamp_shift(exp_diff);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        state_next = (align_shift != '0) ? SHIFT : ADD;
      end
      SHIFT: begin
        if (shift_cnt == SHIFT_W'(1)) begin
          state_next = ADD;
        end
      end
      ADD: begin
        state_next = NORM;
      end
      NORM: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_a        <= '0;
      exp_b        <= '0;
      fract_a      <= '0;
      fract_b      <= '0;
      big_exp      <= '0;
      big_mant     <= '0;
      small_mant   <= '0;
      shift_cnt    <= '0;
      sum          <= '0;
      result_exp   <= '0;
      result_fract <= '0;
      overflow     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            exp_a   <= expA;
            exp_b   <= expB;
            fract_a <= fractA;
            fract_b <= fractB;
          end
        end
        ALIGN: begin
          shift_cnt <= align_shift;
          if (a_big) begin
            big_exp    <= exp_a;
            big_mant   <= {1'b1, fract_a, {GUARD_W{1'b0}}};
            small_mant <= {1'b1, fract_b, {GUARD_W{1'b0}}};
          end else begin
            big_exp    <= exp_b;
            big_mant   <= {1'b1, fract_b, {GUARD_W{1'b0}}};
            small_mant <= {1'b1, fract_a, {GUARD_W{1'b0}}};
          end
        end
        SHIFT: begin
          small_mant <= small_mant >> 1;
          shift_cnt  <= shift_cnt - SHIFT_W'(1);
        end
        ADD: begin
          sum <= {1'b0, big_mant} + {1'b0, small_mant};
        end
        NORM: begin
          result_exp   <= norm_exp;
          result_fract <= norm_fract;
          overflow     <= norm_ovf;
        end
        default: begin
        end
      endcase
    end
  end

  fp_norm_round u_norm (
    .sum       (sum),
    .exp_big   (big_exp),
    .res_exp   (norm_exp),
    .res_fract (norm_fract),
    .res_ovf   (norm_ovf)
  );

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed plan cases plus random pairs against an arithmetic model.
module tb_fp_add_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] expA, expB;
  logic [3:0] fractA, fractB;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] result_exp;
  logic [3:0] result_fract;
  logic       overflow;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  fp_add_seq dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .expA         (expA),
    .fractA       (fractA),
    .expB         (expB),
    .fractB       (fractB),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_exp   (result_exp),
    .result_fract (result_fract),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value-level model: mantissas scaled by 4 for the guard bits, integer shift, then requantize.
  function automatic void model(input int ea, input int fa, input int eb, input int fb,
                                output int re, output int rf, output int ov, output int lat);
    int bm, sm, be, d, s, q, k, e;
    if (ea >= eb) begin
      be = ea; bm = (16 + fa) * 4; sm = (16 + fb) * 4; d = ea - eb;
    end else begin
      be = eb; bm = (16 + fb) * 4; sm = (16 + fa) * 4; d = eb - ea;
    end
    sm  = sm >> d;
    lat = 3 + ((d > 7) ? 7 : d);
    s   = bm + sm;
    if (s >= 128) begin
      k = 3; e = be + 1;
    end else begin
      k = 2; e = be;
    end
    q = s >> k;
`ifdef FP_ADD_ROUND_EN
    begin
      int r;
      r = s - (q << k);
      if (r > (1 << (k - 1)) || (r == (1 << (k - 1)) && (q % 2) == 1)) q++;
      if (q == 32) begin
        q = 16; e++;
      end
    end
`endif
    if (e > 7) begin
      re = 7; rf = 15; ov = 1;
    end else begin
      re = e; rf = q - 16; ov = 0;
    end
  endfunction

  task automatic run_op(input int ea, input int fa, input int eb, input int fb,
                        input int hold, input string tag);
    int re, rf, ov, lat, cyc;
    model(ea, fa, eb, fb, re, rf, ov, lat);
    cyc = 0;
    while (!in_ready && cyc < 30) begin
      tick();
      cyc++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    expA = 3'(ea); fractA = 4'(fa); expB = 3'(eb); fractB = 4'(fb);
    tick();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk({tag, "_busy"}, 32'({in_ready, busy}), 32'b01);
      // Anything on the input side must be ignored while busy.
      in_valid = 1'($urandom);
      expA = 3'($urandom); fractA = 4'($urandom); expB = 3'($urandom); fractB = 4'($urandom);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_exp"}, 32'(result_exp), 32'(re));
    chk({tag, "_fract"}, 32'(result_fract), 32'(rf));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold"}, 32'({out_valid, in_ready, result_exp, result_fract, overflow}),
          32'({1'b1, 1'b0, 3'(re), 4'(rf), 1'(ov)}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  initial begin
    int re, rf, ov, lat;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    expA = '0; fractA = '0; expB = '0; fractB = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("reset_result", 32'({result_exp, result_fract, overflow}), 32'd0);

    // Pin the model against hand-computed results.
    model(3, 4, 1, 8, re, rf, ov, lat);
    chk("model_align", 32'({re, rf, ov, lat}), 32'({3, 10, 0, 5}));
    model(2, 8, 2, 8, re, rf, ov, lat);
    chk("model_carry", 32'({re, rf, ov, lat}), 32'({3, 8, 0, 3}));
    model(7, 15, 7, 15, re, rf, ov, lat);
    chk("model_ovf", 32'({re, rf, ov}), 32'({7, 15, 1}));
    model(7, 0, 0, 15, re, rf, ov, lat);
    chk("model_clamp", 32'({re, rf, ov, lat}), 32'({7, 0, 0, 10}));
    model(2, 0, 0, 14, re, rf, ov, lat);
`ifdef FP_ADD_ROUND_EN
    chk("model_round", 32'(rf), 32'd8);
`else
    chk("model_round", 32'(rf), 32'd7);
`endif

    run_op(3, 4, 1, 8, 0, "align");
    run_op(2, 8, 2, 8, 1, "carry");
    run_op(7, 15, 7, 15, 0, "ovf");
    run_op(7, 0, 0, 15, 5, "clamp");
    run_op(2, 0, 0, 14, 0, "round");
    run_op(1, 8, 3, 4, 2, "swap");

    // Reset while the small operand is still being shifted.
    in_valid = 1'b1;
    expA = 3'd7; fractA = 4'd0; expB = 3'd0; fractB = 4'd15;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_ctrl", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("mid_reset_result", 32'({result_exp, result_fract, overflow}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mid_reset_idle", 32'({in_ready, out_valid}), 32'b10);
    end
    run_op(3, 4, 1, 8, 0, "after_reset");

    for (int n = 0; n < 300; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
